// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES_DEF = 4;
  // Low address bits forced to zero on a redirect target.
  localparam logic [31:0] PC_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC writes and a single-outstanding imem handshake.
// Optional FETCH_CTRL_PERF_EN adds saturating stall/redirect perf counters.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] cur_pc,
  output logic            pc_write,
  output logic [XLEN-1:0] next_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] seq_pc;
  logic            redir_acc;

  assign redirect_tgt = redirect_pc & ~XLEN'(PC_ALIGN_MASK);
  assign seq_pc       = req_pc_q + XLEN'(INSTR_BYTES);
  assign imem_addr    = cur_pc;
  assign if_pc        = req_pc_q;
  // Redirects are not honoured in BOOT: the PC register is still settling.
  assign redir_acc    = redirect_valid && (state_q != BOOT);

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    hold_d   = hold_q;
    imem_req = 1'b0;
    pc_write = 1'b0;
    next_pc  = req_pc_q;
    if_valid = 1'b0;
    if_instr = hold_q;

    if (redir_acc) begin
      pc_write = 1'b1;
      next_pc  = redirect_tgt;
    end

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        if (!redir_acc) begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            req_pc_d = cur_pc;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (redir_acc) begin
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          if_valid = 1'b1;
          if_instr = imem_rdata;
          if (!stall) begin
            pc_write = 1'b1;
            next_pc  = seq_pc;
            state_d  = REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir_acc) begin
          state_d = REQ;
        end else begin
          if_valid = 1'b1;
          if (!stall) begin
            pc_write = 1'b1;
            next_pc  = seq_pc;
            state_d  = REQ;
          end
        end
      end
      DROP: begin
        // A redirect here only retargets the PC; the stale response still
        // has to be swallowed, and once it lands nothing is outstanding.
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      req_pc_q <= RESET_PC;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      hold_q   <= hold_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_valid && stall),
    .clear (1'b0),
    .count (perf_stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redir_acc),
    .clear (1'b0),
    .count (perf_redirect_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a PC-register model in the loop.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] cur_pc;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int checks;
  int failures;

  pc_fetch_ctrl #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .INSTR_BYTES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cur_pc         (cur_pc),
    .pc_write       (pc_write),
    .next_pc        (next_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register owned by the datapath; written by the DUT's pc_write/next_pc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_pc <= 32'h0;
    else if (pc_write) cur_pc <= next_pc;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end checks++;
    if (pc_write !== 1'b0) begin failures++; $display("FAIL rst_pcw got=%0h exp=0", pc_write); end checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_ifv got=%0h exp=0", if_valid); end checks++;
    if (next_pc !== 32'h0) begin failures++; $display("FAIL rst_npc got=%0h exp=0", next_pc); end checks++;
    if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%0h exp=0", if_instr); end checks++;
`ifdef FETCH_CTRL_PERF_EN
    if (perf_stall_cnt !== 32'h0) begin failures++; $display("FAIL rst_perf_stall got=%0h exp=0", perf_stall_cnt); end checks++;
`endif
  endtask

  task automatic test_sequential();
    next_cycle();
    rst_n = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    if (imem_req !== 1'b0 || pc_write !== 1'b0) begin
      failures++; $display("FAIL boot_idle got req=%0h pcw=%0h exp 0 0", imem_req, pc_write);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || if_valid !== 1'b0) begin
        failures++; $display("FAIL seq_req%0d got req=%0h addr=%0h ifv=%0h exp 1 %0h 0", i, imem_req, imem_addr, if_valid, 4 * i);
      end
      checks++;
      if (i == 2) break;
      next_cycle();
      @(negedge clk);
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== 32'h13 ||
          pc_write !== 1'b1 || next_pc !== 32'(4 * i + 4)) begin
        failures++; $display("FAIL seq_xfer%0d got ifv=%0h pc=%0h instr=%0h pcw=%0h npc=%0h exp pc=%0h npc=%0h",
                             i, if_valid, if_pc, if_instr, pc_write, next_pc, 4 * i, 4 * i + 4);
      end
      checks++;
    end
  endtask

  task automatic test_stall();
    // PC 8 request granted in the last sequential cycle; response arrives stalled.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      stall = 1'b1;
      imem_rvalid = (i == 0);
      imem_rdata = (i == 0) ? 32'h0000_0013 : 32'h1111_1111;
      @(negedge clk);
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h13 || pc_write !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got ifv=%0h pc=%0h instr=%0h pcw=%0h exp 1 8 13 0", i, if_valid, if_pc, if_instr, pc_write);
      end
      checks++;
    end
    next_cycle();
    stall = 1'b0;
    @(negedge clk);
    if (if_valid !== 1'b1 || pc_write !== 1'b1 || next_pc !== 32'hC || if_instr !== 32'h13) begin
      failures++; $display("FAIL stall_release got ifv=%0h pcw=%0h npc=%0h instr=%0h exp 1 1 c 13", if_valid, pc_write, next_pc, if_instr);
    end
    checks++;
    next_cycle();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc_write !== 1'b0) begin
      failures++; $display("FAIL stall_single got req=%0h addr=%0h pcw=%0h exp 1 c 0", imem_req, imem_addr, pc_write);
    end
    checks++;
`ifdef FETCH_CTRL_PERF_EN
    if (perf_stall_cnt !== 32'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", perf_stall_cnt); end checks++;
`endif
  endtask

  task automatic test_redirect_drop();
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    if (pc_write !== 1'b1 || next_pc !== 32'h100 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL redir_wait got pcw=%0h npc=%0h req=%0h ifv=%0h exp 1 100 0 0", pc_write, next_pc, imem_req, if_valid);
    end
    checks++;
    next_cycle();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0) begin
      failures++; $display("FAIL drop_stale got ifv=%0h req=%0h pcw=%0h exp 0 0 0", if_valid, imem_req, pc_write);
    end
    checks++;
    next_cycle();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL drop_refetch got req=%0h addr=%0h exp 1 100", imem_req, imem_addr);
    end
    checks++;
  endtask

  task automatic test_redirect_rvalid();
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    if (if_valid !== 1'b0 || pc_write !== 1'b1 || next_pc !== 32'h200 || imem_req !== 1'b0) begin
      failures++; $display("FAIL redir_rvalid got ifv=%0h pcw=%0h npc=%0h req=%0h exp 0 1 200 0", if_valid, pc_write, next_pc, imem_req);
    end
    checks++;
    next_cycle();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin
      failures++; $display("FAIL redir_rvalid_req got req=%0h addr=%0h ifv=%0h exp 1 200 0", imem_req, imem_addr, if_valid);
    end
    checks++;
`ifdef FETCH_CTRL_PERF_EN
    if (perf_redirect_cnt !== 32'd2) begin failures++; $display("FAIL perf_redir got=%0d exp=2", perf_redirect_cnt); end checks++;
`endif
  endtask

  task automatic test_wrap();
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    if (next_pc !== 32'hFFFF_FFFC || pc_write !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL wrap_redir got npc=%0h pcw=%0h req=%0h exp fffffffc 1 0", next_pc, pc_write, imem_req);
    end
    checks++;
    next_cycle();
    redirect_valid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin
      failures++; $display("FAIL wrap_req got addr=%0h req=%0h exp fffffffc 1", imem_addr, imem_req);
    end
    checks++;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    if (if_pc !== 32'hFFFF_FFFC || pc_write !== 1'b1 || next_pc !== 32'h0) begin
      failures++; $display("FAIL wrap_xfer got pc=%0h pcw=%0h npc=%0h exp fffffffc 1 0", if_pc, pc_write, next_pc);
    end
    checks++;
  endtask

  task automatic test_reset_in_hold();
    next_cycle();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093; stall = 1'b1;
    next_cycle();
    imem_rvalid = 1'b0;
    @(negedge clk);
    if (if_valid !== 1'b1 || if_instr !== 32'h93 || if_pc !== 32'h0) begin
      failures++; $display("FAIL hold_pre_rst got ifv=%0h instr=%0h pc=%0h exp 1 93 0", if_valid, if_instr, if_pc);
    end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0 ||
        next_pc !== 32'h0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      failures++; $display("FAIL async_rst got ifv=%0h req=%0h pcw=%0h npc=%0h pc=%0h instr=%0h exp all 0",
                           if_valid, imem_req, pc_write, next_pc, if_pc, if_instr);
    end
    checks++;
`ifdef FETCH_CTRL_PERF_EN
    if (perf_stall_cnt !== 32'h0 || perf_redirect_cnt !== 32'h0) begin
      failures++; $display("FAIL async_rst_perf got stall=%0h redir=%0h exp 0 0", perf_stall_cnt, perf_redirect_cnt);
    end
    checks++;
`endif
    stall = 1'b0;
    next_cycle();
    rst_n = 1'b1; imem_gnt = 1'b0;
    @(negedge clk);
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL post_rst_boot got req=%0h ifv=%0h exp 0 0", imem_req, if_valid);
    end
    checks++;
    next_cycle();
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL post_rst_req got req=%0h addr=%0h exp 1 0", imem_req, imem_addr);
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_redirect_rvalid();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the RISC-V core. It owns the program counter register's `PC_write`/`Next_PC` inputs and drives the instruction-memory request/response handshake. It presents one fetched instruction at a time to the IF/ID pipeline register. Stalls from the hazard unit and redirects from branch/jump resolution are also handled here.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC value the PC register holds out of reset; drives reset values of `next_pc` and `if_pc`.
- `INSTR_BYTES`, 4: sequential PC increment.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cur_pc`, in, XLEN: current value of the PC register.
- `pc_write`, out, 1: PC register write enable.
- `next_pc`, out, XLEN: value written to the PC register when `pc_write`=1.
- `stall`, in, 1: hazard unit; decode cannot accept an instruction this cycle.
- `redirect_valid`, in, 1: branch taken or jump resolved.
- `redirect_pc`, in, XLEN: redirect target.
- `imem_req`, out, 1: instruction memory request.
- `imem_addr`, out, XLEN: request address.
- `imem_gnt`, in, 1: request accepted; meaningful only while `imem_req`=1.
- `imem_rvalid`, in, 1: response valid.
- `imem_rdata`, in, XLEN: response instruction.
- `if_valid`, out, 1: instruction offered to IF/ID.
- `if_pc`, out, XLEN: PC of the offered instruction.
- `if_instr`, out, XLEN: offered instruction.

## Operation
- FSM states:
  - BOOT: one idle cycle after reset release, so the PC register settles.
  - REQ: issue a request.
  - WAIT: one request outstanding.
  - HOLD: response buffered while decode stalls.
  - DROP: discard a stale in-flight response.
- At most one outstanding memory request.
- BOOT:
  - `imem_req`=0 and `pc_write`=0.
  - `redirect_valid` is ignored.
  - Next state is always REQ.
- REQ:
  - `imem_req`=1 and `imem_addr`=`cur_pc`, unless `redirect_valid`.
  - `cur_pc` is latched into the internal `req_pc` on `imem_gnt`, then go to WAIT.
- WAIT, on `imem_rvalid`:
  - `stall`=0: transfer. Drive `if_valid`=1, `if_instr`=`imem_rdata`, `if_pc`=`req_pc`, `pc_write`=1, `next_pc`=`req_pc`+`INSTR_BYTES`. Go to REQ.
  - `stall`=1: capture the response into the hold buffer and go to HOLD.
- HOLD:
  - `if_valid`=1 with buffered data.
  - Transfer on the first cycle with `stall`=0; `pc_write` as in WAIT. Go to REQ.
- Transfer definition: a transfer occurs only on a cycle with `if_valid` && !`stall`. `pc_write`=1 on exactly those cycles, except for redirects.
- Redirect (highest priority, every state except BOOT):
  - Outputs: `pc_write`=1, `next_pc`={`redirect_pc`[XLEN-1:2],2'b00}, `imem_req`=0, `if_valid`=0 that cycle.
  - From REQ, go to REQ.
  - From HOLD, discard the buffer and go to REQ.
  - From WAIT without `imem_rvalid`, go to DROP.
  - From WAIT with `imem_rvalid` in the same cycle, discard the response and go to REQ.
  - From DROP, stay in DROP.
- DROP: `imem_req`=0; on `imem_rvalid`, discard and go to REQ.
- Address arithmetic is modulo 2^XLEN: `req_pc`=32'hFFFF_FFFC gives `next_pc`=0.

## Timing
- `pc_write`, `next_pc`, `imem_req`, `imem_addr` and `if_valid` are combinational from state and inputs. State and buffers are registered.
- The PC register updates on the edge that closes the transfer or redirect cycle. The next REQ cycle sees the new `cur_pc`.
- Best-case throughput is 1 instruction per 2 cycles: REQ with `gnt`, then WAIT with `rvalid`.
- Reset values (while `rst_n`=0):
  - state=BOOT.
  - `imem_req`=0, `pc_write`=0, `if_valid`=0.
  - `next_pc`=`RESET_PC`, `if_pc`=`RESET_PC`, `if_instr`=0.
  - Perf counters=0.
- Reset mid-operation: the FSM returns to BOOT immediately. Instruction memory shares `rst_n`, so no stale response survives reset.

## Configuration
- `FETCH_CTRL_PERF_EN` defined: adds outputs `perf_stall_cnt` and `perf_redirect_cnt`, each 32 bits, saturating at 32'hFFFF_FFFF.
  - `perf_stall_cnt` increments on each cycle with `if_valid` && `stall`.
  - `perf_redirect_cnt` increments on each accepted redirect.
- `FETCH_CTRL_PERF_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `fetch_pkg` holds:
  - the FSM state enum `fetch_state_e` (BOOT, REQ, WAIT, HOLD, DROP);
  - the constants `INSTR_BYTES_DEF` and `PC_ALIGN_MASK`.
- Sub-module `sat_counter` (width parameter, inc, clear) is instantiated twice under `FETCH_CTRL_PERF_EN`.

## Test plan
- Reset release, `gnt` and `rvalid` always 1, `rdata`=32'h0000_0013:
  - BOOT for 1 cycle.
  - Then `if_pc`=0, 4, 8 on alternating cycles; `pc_write` pulses with `next_pc`=4, 8, 12.
- `stall`=1 for 3 cycles when `rvalid` arrives for PC 8:
  - HOLD, with `if_valid` held and `if_pc`=8 stable.
  - `pc_write`=0 during the stall; a single transfer once `stall`=0.
  - `perf_stall_cnt`=3.
- In WAIT for PC 12, `redirect_valid`=1 with `redirect_pc`=32'h0000_0103:
  - `next_pc`=32'h100 and the FSM enters DROP.
  - A late `rvalid` with 32'hDEAD_BEEF is not offered.
  - The next request has `imem_addr`=32'h100.
- `redirect_valid` and `imem_rvalid` in the same WAIT cycle: the response is dropped, `if_valid`=0, and the next state is REQ at the redirect target.
- `req_pc`=32'hFFFF_FFFC transfer: `next_pc`=0.
- `rst_n` asserted during HOLD: all outputs return to reset values asynchronously, and BOOT follows release.
